// File: rtl/rst_ctrl_multi.sv
// APB-programmable multi-channel reset controller: per-channel software level control
// plus self-timed reset pulses of programmable width.
module rst_ctrl_multi #(
  parameter int              ADDR_WIDTH = 8,
  parameter int              DATA_WIDTH = 32,
  parameter int              N_CH       = 4,
  parameter int              CNT_W      = 16,
  parameter logic [N_CH-1:0] RST_INIT   = '0,
  parameter int              PULSE_DEF  = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic                  penable,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic [N_CH-1:0]       rst_n_o
);

  localparam logic [ADDR_WIDTH-1:0] REG_CTRL   = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] REG_PULSE  = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] REG_WIDTH  = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] REG_STATUS = ADDR_WIDTH'(32'h0C);

  logic [N_CH-1:0]       ctrl_r;
  logic [CNT_W-1:0]      width_r;
  logic [N_CH-1:0]       busy_r;
  logic [CNT_W-1:0]      cnt_r [N_CH];
  logic [DATA_WIDTH-1:0] prdata_r;

  logic                  wr_s;
  logic                  rd_s;
  logic [N_CH-1:0]       trig_s;
  logic [CNT_W-1:0]      width_eff_s;
  logic [N_CH-1:0]       rst_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_s;

  assign wr_s     = psel & penable & pwrite;
  assign rd_s     = psel & ~penable & ~pwrite;
  assign rst_s    = ctrl_r & ~busy_r;
  assign rst_n_o  = rst_s;
  assign prdata   = prdata_r;
  assign unused_s = &{1'b0, pwdata};

  // Decode pulse triggers and the effective pulse length (zero behaves as one cycle)
  always_comb begin
    trig_s      = '0;
    width_eff_s = width_r;
    if (wr_s && (paddr == REG_PULSE)) begin
      trig_s = pwdata[N_CH-1:0];
    end else begin
      trig_s = '0;
    end
    if (width_r == '0) begin
      width_eff_s = CNT_W'(1);
    end else begin
      width_eff_s = width_r;
    end
  end

  // Software-visible CTRL and WIDTH registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl_r  <= RST_INIT;
      width_r <= CNT_W'(PULSE_DEF);
    end else if (wr_s && (paddr == REG_CTRL)) begin
      ctrl_r  <= pwdata[N_CH-1:0];
    end else if (wr_s && (paddr == REG_WIDTH)) begin
      width_r <= pwdata[CNT_W-1:0];
    end
  end

  // Per-channel pulse timers; a new trigger reloads and beats the terminal-count clear
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      busy_r <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (trig_s[i]) begin
          busy_r[i] <= 1'b1;
          cnt_r[i]  <= width_eff_s;
        end else if (busy_r[i]) begin
          if (cnt_r[i] == CNT_W'(1)) begin
            busy_r[i] <= 1'b0;
          end else begin
            cnt_r[i] <= cnt_r[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  // Read data mux; unmapped addresses and unimplemented bits read as zero
  always_comb begin
    rdata_s = '0;
    case (paddr)
      REG_CTRL:   rdata_s[N_CH-1:0]  = ctrl_r;
      REG_PULSE:  rdata_s[N_CH-1:0]  = busy_r;
      REG_WIDTH:  rdata_s[CNT_W-1:0] = width_r;
      REG_STATUS: rdata_s[N_CH-1:0]  = ~rst_s;
      default:    rdata_s            = '0;
    endcase
  end

  // Read data is captured in the setup phase and held until the next read
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata_r <= '0;
    end else if (rd_s) begin
      prdata_r <= rdata_s;
    end else begin
      prdata_r <= prdata_r;
    end
  end

endmodule

// File: tb/tb_rst_ctrl_multi.sv
// Bench for rst_ctrl_multi: time-based reference model, read scoreboard, directed and random APB traffic.
module tb_rst_ctrl_multi;

  localparam int N_CH = 4;

  logic        pclk    = 1'b0;
  logic        presetn = 1'b0;
  logic        psel    = 1'b0;
  logic        pwrite  = 1'b0;
  logic        penable = 1'b0;
  logic [7:0]  paddr   = 8'h00;
  logic [31:0] pwdata  = 32'h0;
  logic [31:0] prdata;
  logic [3:0]  rst_n_o;

  int tests = 0;
  int fails = 0;

  // Model state: a pulse on channel i is active while the edge index is below end_t[i]
  int          cyc = 0;
  int          end_t [N_CH];
  logic [3:0]  m_ctrl  = 4'h0;
  logic [15:0] m_width = 16'd16;
  logic [31:0] exp_q [$];

  always #5 pclk = ~pclk;

  rst_ctrl_multi dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr), .pwrite(pwrite),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .rst_n_o(rst_n_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_busy(input int at);
    logic [3:0] b;
    for (int i = 0; i < N_CH; i++) b[i] = (at < end_t[i]);
    return b;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [3:0] b;
    b = m_busy(cyc);
    case (a)
      8'h00:   return {28'h0, m_ctrl};
      8'h04:   return {28'h0, b};
      8'h08:   return {16'h0, m_width};
      8'h0C:   return {28'h0, ~(m_ctrl & ~b)};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: pushes read expectations at the setup edge, applies writes at the access edge
  initial begin
    for (int i = 0; i < N_CH; i++) end_t[i] = 0;
    forever begin
      @(posedge pclk or negedge presetn);
      if (!presetn) begin
        m_ctrl  = 4'h0;
        m_width = 16'd16;
        for (int i = 0; i < N_CH; i++) end_t[i] = 0;
        exp_q.delete();
      end else begin
        if (psel && !penable && !pwrite) exp_q.push_back(m_read(paddr));
        cyc++;
        if (psel && penable && pwrite) begin
          case (paddr)
            8'h00: m_ctrl = pwdata[3:0];
            8'h04: for (int i = 0; i < N_CH; i++)
                     if (pwdata[i]) end_t[i] = cyc + ((m_width == 16'd0) ? 1 : int'(m_width));
            8'h08: m_width = pwdata[15:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: every cycle compares outputs with the model and drains read expectations
  initial begin
    forever begin
      @(negedge pclk);
      check("rst_n_o", {28'h0, rst_n_o}, {28'h0, m_ctrl & ~m_busy(cyc)});
      if (presetn && psel && penable && !pwrite) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL read_unexpected: got 0x%0h, expected no read data", prdata);
        end else begin
          check("prdata", prdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Counts consecutive low cycles of one channel, bounded
  task automatic measure(input int ch, input int exp, input string name);
    int  n = 0;
    int  guard = 0;
    bit  done = 1'b0;
    while (!done && guard < 70000) begin
      @(negedge pclk);
      guard++;
      if (rst_n_o[ch] == 1'b0) n++;
      else done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s: channel %0d still low after %0d cycles, expected %0d", name, ch, n, exp);
    end else begin
      check(name, n, exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    int          op;
    logic [7:0]  addrs [6];

    repeat (3) @(posedge pclk);
    #1;
    check("reset_out", {28'h0, rst_n_o}, 32'h0);
    presetn = 1'b1;

    // Level control and status
    apb_wr(8'h00, 32'hF);
    apb_wr(8'h00, 32'h5);
    apb_rd(8'h0C);

    // Single pulse of width 3 on channel 1
    apb_wr(8'h00, 32'hF);
    apb_wr(8'h08, 32'd3);
    apb_wr(8'h04, 32'h2);
    fork
      measure(1, 3, "pulse_w3");
      apb_rd(8'h04);
    join
    apb_rd(8'h04);

    // Retrigger channel 0 four cycles in, concurrent start on channel 3
    apb_wr(8'h08, 32'd10);
    apb_wr(8'h04, 32'h1);
    fork
      measure(0, 14, "retrig_ch0");
      begin
        @(posedge pclk);
        apb_wr(8'h04, 32'h9);
        measure(3, 10, "conc_ch3");
      end
    join

    // Width boundaries and width change during a running pulse
    apb_wr(8'h08, 32'd0);
    apb_wr(8'h04, 32'h1);
    measure(0, 1, "width_zero");
    apb_wr(8'h08, 32'hFFFF);
    apb_wr(8'h04, 32'h4);
    measure(2, 65535, "width_max");
    apb_wr(8'h08, 32'd6);
    apb_wr(8'h04, 32'h1);
    fork
      measure(0, 6, "width_mid_change");
      apb_wr(8'h08, 32'd2);
    join
    apb_rd(8'h08);

    // CTRL cleared during a pulse holds the channel after expiry; unmapped access
    apb_wr(8'h08, 32'd5);
    apb_wr(8'h04, 32'h4);
    apb_wr(8'h00, 32'hB);
    idle(8);
    check("ch2_held", {31'h0, rst_n_o[2]}, 32'h0);
    apb_wr(8'h00, 32'hF);
    check("ch2_release", {31'h0, rst_n_o[2]}, 32'h1);
    apb_wr(8'h10, 32'hFFFF_FFFF);
    apb_rd(8'h00);
    apb_rd(8'h08);
    apb_rd(8'h10);
    apb_rd(8'h04);
    apb_rd(8'h0C);

    // Randomized traffic
    addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08;
    addrs[3] = 8'h0C; addrs[4] = 8'h10; addrs[5] = 8'h00;
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 6);
      d  = $urandom;
      a  = addrs[$urandom_range(0, 4)];
      case (op)
        0:       apb_wr(8'h00, d);
        1, 2:    apb_wr(8'h04, d);
        3:       apb_wr(8'h08, (d & 32'hFFFF_0000) | 32'($urandom_range(0, 12)));
        4:       apb_rd(a);
        5:       begin a = d[7:0]; apb_wr(a, $urandom); apb_rd(a); end
        default: idle($urandom_range(1, 4));
      endcase
    end

    // Reset in the middle of running pulses
    apb_wr(8'h00, 32'hF);
    apb_wr(8'h08, 32'd20);
    apb_wr(8'h04, 32'hF);
    idle(3);
    presetn = 1'b0;
    #1;
    check("reset_mid_out", {28'h0, rst_n_o}, 32'h0);
    check("reset_prdata", prdata, 32'h0);
    idle(2);
    presetn = 1'b1;
    apb_rd(8'h00);
    apb_rd(8'h08);
    apb_rd(8'h04);

    idle(3);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
